// File: rtl/board_pkg.sv
// Shared constants for the board debug controller: display blank code,
// mode encoding and the counter-width helper used by every divider.
package board_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_STEP = 1'b1;

  // Width needed to hold 0..n-1, never less than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus stability-counter debouncer; emits a one-cycle
// press pulse on each debounced rising edge.
module btn_debounce
  import board_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int DB_W = cnt_w(DB_CYCLES);

  logic            btn_s1;
  logic            btn_s;
  logic            state;
  logic            state_q;
  logic [DB_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_s1  <= 1'b0;
      btn_s   <= 1'b0;
      state   <= 1'b0;
      state_q <= 1'b0;
      cnt     <= '0;
      press   <= 1'b0;
    end else begin
      btn_s1 <= btn;
      btn_s  <= btn_s1;
      // Any return to the debounced level restarts the stability window.
      if (btn_s == state) begin
        cnt <= '0;
      end else if (cnt == DB_W'(DB_CYCLES - 1)) begin
        state <= btn_s;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
      state_q <= state;
      press   <= state & ~state_q;
    end
  end

endmodule

// File: rtl/hex7seg.sv
// Combinational hex digit to active-low seven-segment decoder, {g,f,e,d,c,b,a}.
module hex7seg
  import board_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      4'hF: seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/board_debug_ctrl.sv
// Board debug controller: run/step clock-enable generation, step counter and
// a multiplexed hex display of an inspection word with leading-zero blanking.
module board_debug_ctrl
  import board_pkg::*;
#(
  parameter int CLK_HZ    = 100_000_000,
  parameter int RUN_HZ    = 1,
  parameter int SCAN_HZ   = 760,
  parameter int DIGITS    = 8,
  parameter int DATA_W    = 32,
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 16
) (
  input  logic              CLK100MHZ,
  input  logic              RST_N,
  input  logic              mode,
  input  logic              step_btn,
  input  logic              blank_lead,
  input  logic [DATA_W-1:0] disp_data,
  output logic              cpu_en,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              dp,
  output logic [CNT_W-1:0]  step_count
);

  localparam int RUN_DIV  = CLK_HZ / RUN_HZ;
  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
  localparam int RUN_W    = cnt_w(RUN_DIV);
  localparam int SCAN_W   = cnt_w(SCAN_DIV);
  localparam int IDX_W    = cnt_w(DIGITS);

  logic              mode_s1;
  logic              mode_s;
  logic              mode_chg;
  logic [RUN_W-1:0]  run_cnt;
  logic              run_end;
  logic              tick;
  logic              press;
  logic [SCAN_W-1:0] scan_cnt;
  logic              scan_tick;
  logic [IDX_W-1:0]  idx;
  logic              idx_last;
  logic              loaded;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] rest;
  logic              lead_blank;
  logic [6:0]        hex_seg;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_btn (
    .clk   (CLK100MHZ),
    .rst_n (RST_N),
    .btn   (step_btn),
    .press (press)
  );

  assign mode_chg  = mode_s1 != mode_s;
  assign run_end   = run_cnt == RUN_W'(RUN_DIV - 1);
  assign scan_tick = scan_cnt == SCAN_W'(SCAN_DIV - 1);
  assign idx_last  = idx == IDX_W'(DIGITS - 1);

  // The first frame after reset shows the live word, matching what the shadow captures.
  assign cur_word   = loaded ? shadow : disp_data;
  assign rest       = cur_word >> {idx, 2'b00};
  assign lead_blank = blank_lead && (idx != '0) && (rest == '0);

  hex7seg u_hex (
    .nib (rest[3:0]),
    .seg (hex_seg)
  );

  // Stage p1: run tick; stage p2: registered enable and step count.
  always_ff @(posedge CLK100MHZ) begin
    if (!RST_N) begin
      mode_s1    <= MODE_RUN;
      mode_s     <= MODE_RUN;
      run_cnt    <= '0;
      tick       <= 1'b0;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      mode_s1 <= mode;
      mode_s  <= mode_s1;
      run_cnt <= (mode_chg || run_end) ? '0 : run_cnt + RUN_W'(1);
      tick    <= run_end && !mode_chg;
      cpu_en  <= (mode_s == MODE_STEP) ? press : tick;
      step_count <= step_count + CNT_W'(cpu_en);
    end
  end

  // Display stage: index, shadow word and the registered an/seg/dp triple.
  always_ff @(posedge CLK100MHZ) begin
    if (!RST_N) begin
      scan_cnt <= '0;
      idx      <= '0;
      loaded   <= 1'b0;
      shadow   <= '0;
      seg      <= SEG_BLANK;
      an       <= '1;
      dp       <= 1'b1;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + SCAN_W'(1);
      if (scan_tick) idx <= idx_last ? '0 : idx + IDX_W'(1);
      loaded <= 1'b1;
      if (!loaded || (scan_tick && idx_last)) shadow <= disp_data;
      an  <= ~(DIGITS'(1) << idx);
      seg <= lead_blank ? SEG_BLANK : hex_seg;
      dp  <= !((idx == '0) && (mode_s == MODE_STEP));
    end
  end

endmodule

// File: tb/tb_board_debug_ctrl.sv
// Scoreboard bench for board_debug_ctrl: expected pulses and digit frames are
// queued by the stimulus and consumed by an independent output monitor.
module tb_board_debug_ctrl;

  localparam int CLK_HZ    = 1000;
  localparam int RUN_HZ    = 100;
  localparam int SCAN_HZ   = 500;
  localparam int DIGITS    = 8;
  localparam int DATA_W    = 32;
  localparam int DB_CYCLES = 4;
  localparam int CNT_W     = 16;
  localparam int RUN_DIV   = CLK_HZ / RUN_HZ;
  localparam int SCAN_DIV  = CLK_HZ / SCAN_HZ;
  // Press latency from a stable-high input: 2 sync + DB_CYCLES + edge + register.
  localparam int PRESS_LAT = 2 + DB_CYCLES + 2;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              mode = 1'b0;
  logic              step_btn = 1'b0;
  logic              blank_lead = 1'b0;
  logic [DATA_W-1:0] disp_data = '0;
  logic              cpu_en;
  logic [6:0]        seg;
  logic [DIGITS-1:0] an;
  logic              dp;
  logic [CNT_W-1:0]  step_count;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int exp_steps = 0;
  int pulse_q[$];
  logic [15:0] disp_q[$];

  logic [6:0] FONT [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  board_debug_ctrl #(
    .CLK_HZ(CLK_HZ), .RUN_HZ(RUN_HZ), .SCAN_HZ(SCAN_HZ), .DIGITS(DIGITS),
    .DATA_W(DATA_W), .DB_CYCLES(DB_CYCLES), .CNT_W(CNT_W)
  ) dut (
    .CLK100MHZ (clk),
    .RST_N     (rst_n),
    .mode      (mode),
    .step_btn  (step_btn),
    .blank_lead(blank_lead),
    .disp_data (disp_data),
    .cpu_en    (cpu_en),
    .seg       (seg),
    .an        (an),
    .dp        (dp),
    .step_count(step_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
    $fatal(1);
  end

  // Expected {an, seg, dp} for digit i of word w.
  function automatic logic [15:0] exp_digit(input logic [31:0] w, input int i,
                                            input logic bl, input logic md);
    logic [31:0] sh;
    logic [6:0]  s;
    logic [7:0]  a;
    sh = w >> (4 * i);
    s  = FONT[sh[3:0]];
    if (bl && i > 0 && sh == 0) s = 7'h7F;
    a = ~(8'd1 << i);
    return {a, s, !(i == 0 && md)};
  endfunction

  // Output monitor: pops expectations whenever the DUT presents a pulse or a new digit.
  logic [7:0] an_prev = 8'hFF;
  int last_chg = 0;
  always @(negedge clk) begin
    int e;
    logic [15:0] ex;
    if (cpu_en === 1'b1) begin
      checks++;
      if (pulse_q.size() == 0) begin
        errors++;
        $display("FAIL cpu_en_unexpected: pulse at cycle %0d, expected none", cyc);
      end else begin
        e = pulse_q.pop_front();
        if (e != cyc) begin
          errors++;
          $display("FAIL cpu_en_cycle: pulse at cycle %0d, expected cycle %0d", cyc, e);
        end
      end
    end
    if (an !== an_prev) begin
      if (an !== 8'hFF && an_prev !== 8'hFF) begin
        checks++;
        if (cyc - last_chg != SCAN_DIV) begin
          errors++;
          $display("FAIL digit_dwell: dwell %0d cycles, expected %0d", cyc - last_chg, SCAN_DIV);
        end
      end
      if (disp_q.size() > 0) begin
        ex = disp_q.pop_front();
        checks++;
        if ({an, seg, dp} !== ex) begin
          errors++;
          $display("FAIL digit: an=%h seg=%h dp=%b, expected an=%h seg=%h dp=%b",
                   an, seg, dp, ex[15:8], ex[7:1], ex[0]);
        end
      end
      last_chg = cyc;
      an_prev  = an;
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Show w0; from the next frame start expect its digits 1..7, then optionally
  // a full frame of w0 or, after a mid-scan change, a full frame of w1.
  task automatic disp_test(input logic [31:0] w0, input logic bl, input logic md,
                           input int full, input logic [31:0] w1);
    logic [7:0] prev;
    bit found;
    disp_data  = w0;
    blank_lead = bl;
    wait_cycles(2);
    prev  = an;
    found = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(negedge clk);
      if (an == 8'hFE && prev != 8'hFE) found = 1;
      prev = an;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_start: no digit-0 frame start seen, expected one within 40 cycles");
    end
    @(posedge clk);
    for (int i = 1; i < DIGITS; i++) disp_q.push_back(exp_digit(w0, i, bl, md));
    if (full == 1) begin
      for (int i = 0; i < DIGITS; i++) disp_q.push_back(exp_digit(w0, i, bl, md));
    end else if (full == 2) begin
      wait_cycles(3);
      disp_data = w1;
      for (int i = 0; i < DIGITS; i++) disp_q.push_back(exp_digit(w1, i, bl, md));
    end
    for (int k = 0; k < 40 && disp_q.size() != 0; k++) @(negedge clk);
    checks++;
    if (disp_q.size() != 0) begin
      errors++;
      $display("FAIL frame_drain: %0d digits not presented, expected 0", disp_q.size());
      disp_q.delete();
    end
  endtask

  // One step-mode press with random sub-threshold bounces before it.
  task automatic step_press(input int bounces);
    int t;
    for (int b = 0; b < bounces; b++) begin
      step_btn = 1'b1;
      wait_cycles($urandom_range(1, DB_CYCLES - 1));
      step_btn = 1'b0;
      wait_cycles($urandom_range(1, 3));
    end
    step_btn = 1'b1;
    t = cyc;
    pulse_q.push_back(t + PRESS_LAT);
    exp_steps++;
    wait_cycles($urandom_range(6, 12));
    step_btn = 1'b0;
    wait_cycles(12);
  endtask

  initial begin
    int rel;
    int m;
    logic [31:0] w;
    logic [31:0] w2;

    // Reset state
    wait_cycles(3);
    check("reset_cpu_en", cpu_en, 0);
    check("reset_seg", seg, 7'h7F);
    check("reset_an", an, 8'hFF);
    check("reset_dp", dp, 1);
    check("reset_step_count", step_count, 0);

    // Run mode from reset release: pulses at release+11, +21, +31
    w = $urandom;
    w = w >> (4 * $urandom_range(1, 7));
    disp_data  = w;
    blank_lead = 1'b1;
    rst_n = 1'b1;
    rel = cyc;
    for (int k = 0; k < 3; k++) pulse_q.push_back(rel + RUN_DIV + 1 + k * RUN_DIV);
    exp_steps = 3;
    disp_test(w, 1'b1, 1'b0, 0, 32'h0);
    // Switch to step so the synchronised mode lands exactly on the tick edge.
    while (cyc < rel + 4 * RUN_DIV - 2) @(negedge clk);
    mode = 1'b1;
    wait_cycles(8);
    check("run_step_count", step_count, exp_steps);
    check("run_pulses_done", pulse_q.size(), 0);

    // Step mode: spec bounce 1-0-1 at 2-cycle spacing, then random bounce presses
    step_btn = 1'b1; wait_cycles(2);
    step_btn = 1'b0; wait_cycles(2);
    step_press(0);
    check("step_one_press", step_count, exp_steps);
    for (int p = 0; p < 4; p++) step_press($urandom_range(0, 3));
    check("step_presses", step_count, exp_steps);
    check("step_pulses_done", pulse_q.size(), 0);

    // Display: blanking, mid-scan change, random words
    disp_test(32'h0000_00A5, 1'b1, 1'b1, 1, 32'h0);
    disp_test(32'h0000_00A5, 1'b0, 1'b1, 1, 32'h0);
    disp_test(32'h1234_5678, 1'b0, 1'b1, 2, 32'hFFFF_FFFF);
    for (int r = 0; r < 3; r++) begin
      w  = $urandom;
      w  = w >> (4 * $urandom_range(0, 7));
      w2 = $urandom;
      disp_test(w, 1'($urandom_range(0, 1)), 1'b1, $urandom_range(1, 2), w2);
    end

    // Step -> run: first tick a full period after the synchronised change; button ignored
    mode = 1'b0;
    m = cyc;
    pulse_q.push_back(m + 2 + RUN_DIV + 1);
    pulse_q.push_back(m + 2 + 2 * RUN_DIV + 1);
    exp_steps += 2;
    wait_cycles(3);
    step_btn = 1'b1; wait_cycles(8);
    step_btn = 1'b0;
    while (cyc < m + 26) @(negedge clk);
    mode = 1'b1;
    wait_cycles(10);
    check("rerun_step_count", step_count, exp_steps);
    check("rerun_pulses_done", pulse_q.size(), 0);

    // Reset mid-press and mid-scan
    step_btn = 1'b1;
    wait_cycles(3);
    rst_n = 1'b0;
    step_btn = 1'b0;
    wait_cycles(1);
    check("midrst_an", an, 8'hFF);
    check("midrst_seg", seg, 7'h7F);
    check("midrst_cpu_en", cpu_en, 0);
    check("midrst_step_count", step_count, 0);
    check("midrst_dp", dp, 1);
    rst_n = 1'b1;
    exp_steps = 0;
    w = $urandom;
    disp_test(w, 1'b0, 1'b1, 1, 32'h0);
    wait_cycles(10);
    check("final_step_count", step_count, exp_steps);
    check("final_pulses_done", pulse_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
